// File: rtl/despertador_cpu_debug_pkg.sv
// Shared types and jdo field positions for the debug-monitor memory access block.
package despertador_cpu_debug_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRd   = 2'd1,
        StWr   = 2'd2
    } mon_state_e;

    localparam int unsigned JDO_ADDR_LSB  = 17;
    localparam int unsigned JDO_RDEN_BIT  = 35;
    localparam int unsigned JDO_WDATA_MSB = 34;
    localparam int unsigned JDO_WDATA_LSB = 3;
    localparam int unsigned TIMER_W       = 16;

endpackage

// File: rtl/despertador_cpu_debug_wait_timer.sv
// Counts stalled strobe cycles; expired_o fires in the stall cycle that reaches Timeout.
module despertador_cpu_debug_wait_timer #(
    parameter int unsigned Timeout = 255,
    parameter int unsigned CntW    = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Abort so that the strobe is held for exactly Timeout stalled cycles.
    assign expired_o = en_i && (cnt_q == CntW'(Timeout - 1));

endmodule

// File: rtl/despertador_cpu_debug_mon_access.sv
// Executes debug-slave read/write commands on the on-chip debug memory port while the CPU
// is halted, reporting data and status back through MonDReg/monitor_ready/monitor_error.
module despertador_cpu_debug_mon_access
    import despertador_cpu_debug_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              debugack,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              busy
);

    mon_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_inc_d;
    logic [ADDR_W-1:0] jdo_addr;
    logic [31:0]       jdo_wdata;
    logic [ADDR_W-1:0] mem_address_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [31:0]       mem_writedata_q;
    logic [31:0]       mon_dreg_q;
    logic              ready_q;
    logic              error_q;
    logic              any_cmd;
    logic              timer_en;
    logic              timer_expired;
    logic              unused_jdo;

    assign addr_inc_d = addr_q + 1'b1;
    assign jdo_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
    assign jdo_wdata  = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
    assign any_cmd    = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign timer_en   = (mem_read_q | mem_write_q) & mem_waitrequest;
    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    despertador_cpu_debug_wait_timer #(
        .Timeout (TIMEOUT),
        .CntW    (TIMER_W)
    ) u_wait_timer (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .clr_i     (state_q == StIdle),
        .en_i      (timer_en),
        .expired_o (timer_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            mem_address_q   <= '0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_writedata_q <= '0;
            mon_dreg_q      <= '0;
            ready_q         <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_cmd && !debugack) begin
                        error_q <= 1'b1;
                        ready_q <= 1'b0;
                    end else if (any_cmd) begin
                        ready_q <= 1'b0;
                        error_q <= 1'b0;
                        // ocimem_a outranks ocimem_b, which outranks read-next.
                        if (take_action_ocimem_a) begin
                            addr_q <= jdo_addr;
                            if (jdo[JDO_RDEN_BIT]) begin
                                mem_address_q <= jdo_addr;
                                mem_read_q    <= 1'b1;
                                state_q       <= StRd;
                            end else begin
                                ready_q <= 1'b1;
                            end
                        end else if (take_action_ocimem_b) begin
                            mem_writedata_q <= jdo_wdata;
                            mon_dreg_q      <= jdo_wdata;
                            mem_address_q   <= addr_q;
                            mem_write_q     <= 1'b1;
                            state_q         <= StWr;
                        end else begin
                            addr_q        <= addr_inc_d;
                            mem_address_q <= addr_inc_d;
                            mem_read_q    <= 1'b1;
                            state_q       <= StRd;
                        end
                    end
                end
                StRd: begin
                    if (any_cmd) begin
                        error_q <= 1'b1;
                    end
                    if (!mem_waitrequest) begin
                        mon_dreg_q <= mem_readdata;
                        mem_read_q <= 1'b0;
                        ready_q    <= 1'b1;
                        state_q    <= StIdle;
                    end else if (timer_expired) begin
                        mem_read_q <= 1'b0;
                        error_q    <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                StWr: begin
                    if (any_cmd) begin
                        error_q <= 1'b1;
                    end
                    if (!mem_waitrequest) begin
                        addr_q      <= addr_inc_d;
                        mem_write_q <= 1'b0;
                        ready_q     <= 1'b1;
                        state_q     <= StIdle;
                    end else if (timer_expired) begin
                        mem_write_q <= 1'b0;
                        error_q     <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign mem_address   = mem_address_q;
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_writedata = mem_writedata_q;
    assign MonDReg       = mon_dreg_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_despertador_cpu_debug_mon_access.sv
// Scoreboard bench: commands push expected bus accesses, a bus monitor pops and compares them.
module tb_despertador_cpu_debug_mon_access;

    logic        clk;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic        debugack;
    logic [7:0]  mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic        busy;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        int          len;
    } acc_t;

    acc_t        sb_q[$];
    acc_t        exp_acc;
    logic [31:0] mem_model [256];
    logic [31:0] exp_mon;
    int          checks;
    int          errors;
    int          stall_target;
    int          stall_cnt;
    bit          stuck;
    int          mon_len;

    despertador_cpu_debug_mon_access #(
        .ADDR_W  (8),
        .TIMEOUT (4)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .debugack                (debugack),
        .mem_address             (mem_address),
        .mem_read                (mem_read),
        .mem_write               (mem_write),
        .mem_writedata           (mem_writedata),
        .mem_readdata            (mem_readdata),
        .mem_waitrequest         (mem_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .busy                    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [37:0] jdo_a(input logic [7:0] a, input bit rd);
        logic [37:0] j;
        j = '0;
        j[17 +: 8] = a;
        j[35] = rd;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    // Memory slave: stalls each access for stall_target cycles, or forever while stuck.
    initial begin
        mem_waitrequest = 1'b0;
        mem_readdata = '0;
        stall_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_read || mem_write) begin
                mem_waitrequest = stuck || (stall_cnt < stall_target);
                stall_cnt++;
                mem_readdata = mem_model[mem_address];
            end else begin
                mem_waitrequest = 1'b0;
                stall_cnt = 0;
            end
        end
    end

    // Bus monitor: each accepted access must match the head of the scoreboard.
    initial begin
        mon_len = 0;
        forever begin
            @(negedge clk);
            if (mem_read || mem_write) begin
                mon_len++;
                if (!mem_waitrequest) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_access: wr=%0b addr=%h, required none",
                                 mem_write, mem_address);
                    end else begin
                        exp_acc = sb_q.pop_front();
                        if ({mem_write, mem_read, mem_address} !==
                            {exp_acc.wr, !exp_acc.wr, exp_acc.addr} || mon_len != exp_acc.len ||
                            (exp_acc.wr && mem_writedata !== exp_acc.data)) begin
                            errors++;
                            $display("FAIL bus_access: got wr=%0b rd=%0b addr=%h wdata=%h len=%0d, required wr=%0b addr=%h wdata=%h len=%0d",
                                     mem_write, mem_read, mem_address, mem_writedata, mon_len,
                                     exp_acc.wr, exp_acc.addr, exp_acc.data, exp_acc.len);
                        end
                    end
                    if (mem_write) mem_model[mem_address] = mem_writedata;
                end
            end else begin
                mon_len = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic pulse(input bit a, input bit b, input bit na, input logic [37:0] j);
        @(posedge clk);
        #1;
        jdo = j;
        take_action_ocimem_a = a;
        take_action_ocimem_b = b;
        take_no_action_ocimem_a = na;
        @(posedge clk);
        #1;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic push(input bit wr, input logic [7:0] a, input logic [31:0] d, input int len);
        acc_t e;
        e.wr = wr;
        e.addr = a;
        e.data = d;
        e.len = len;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: busy still 1 after 50 cycles, required 0", name);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_read, mem_write, busy, monitor_ready, monitor_error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 00000",
                     {mem_read, mem_write, busy, monitor_ready, monitor_error});
        end
        checks++;
        if (mem_address !== 8'h00) begin
            errors++;
            $display("FAIL reset_addr: got %h, required 00", mem_address);
        end
        checks++;
        if (MonDReg !== 32'h0) begin
            errors++;
            $display("FAIL reset_mondreg: got %h, required 0", MonDReg);
        end
        checks++;
        if (mem_writedata !== 32'h0) begin
            errors++;
            $display("FAIL reset_wdata: got %h, required 0", mem_writedata);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_read();
        stall_target = 0;
        push(1'b0, 8'h10, 32'h0, 1);
        pulse(1'b1, 1'b0, 1'b0, jdo_a(8'h10, 1'b1));
        @(negedge clk);
        checks++;
        if ({busy, monitor_ready} !== 2'b10) begin
            errors++;
            $display("FAIL read_inflight: busy/ready got %b, required 10", {busy, monitor_ready});
        end
        @(negedge clk);
        exp_mon = 32'hCAFEF00D;
        checks++;
        if ({monitor_ready, monitor_error, busy} !== 3'b100 || MonDReg !== exp_mon) begin
            errors++;
            $display("FAIL read_done: rdy/err/busy=%b MonDReg=%h, required 100 %h",
                     {monitor_ready, monitor_error, busy}, MonDReg, exp_mon);
        end
    endtask

    task automatic test_write_wait();
        stall_target = 3;
        push(1'b1, 8'h10, 32'h12345678, 4);
        pulse(1'b0, 1'b1, 1'b0, jdo_b(32'h12345678));
        wait_idle("write_wait");
        exp_mon = 32'h12345678;
        checks++;
        if (monitor_ready !== 1'b1 || MonDReg !== exp_mon) begin
            errors++;
            $display("FAIL write_done: ready=%b MonDReg=%h, required 1 %h",
                     monitor_ready, MonDReg, exp_mon);
        end
        stall_target = 0;
        push(1'b0, 8'h12, 32'h0, 1);
        pulse(1'b0, 1'b0, 1'b1, 38'h0);
        wait_idle("read_next");
        exp_mon = mem_model[8'h12];
        checks++;
        if (MonDReg !== exp_mon || monitor_ready !== 1'b1) begin
            errors++;
            $display("FAIL read_next: MonDReg=%h ready=%b, required %h 1",
                     MonDReg, monitor_ready, exp_mon);
        end
    endtask

    task automatic test_wrap();
        pulse(1'b1, 1'b0, 1'b0, jdo_a(8'hFF, 1'b0));
        @(negedge clk);
        checks++;
        if ({monitor_ready, busy, mem_read} !== 3'b100) begin
            errors++;
            $display("FAIL addr_load: rdy/busy/rd got %b, required 100",
                     {monitor_ready, busy, mem_read});
        end
        push(1'b0, 8'h00, 32'h0, 1);
        pulse(1'b0, 1'b0, 1'b1, 38'h0);
        wait_idle("wrap_read");
        exp_mon = mem_model[8'h00];
        checks++;
        if (MonDReg !== exp_mon) begin
            errors++;
            $display("FAIL wrap_read: MonDReg=%h, required %h", MonDReg, exp_mon);
        end
        pulse(1'b1, 1'b0, 1'b0, jdo_a(8'hFF, 1'b0));
        push(1'b1, 8'hFF, 32'hDEADBEEF, 1);
        pulse(1'b0, 1'b1, 1'b0, jdo_b(32'hDEADBEEF));
        wait_idle("wrap_write");
        push(1'b0, 8'h01, 32'h0, 1);
        pulse(1'b0, 1'b0, 1'b1, 38'h0);
        wait_idle("wrap_post_inc");
        exp_mon = mem_model[8'h01];
        checks++;
        if (MonDReg !== exp_mon) begin
            errors++;
            $display("FAIL wrap_post_inc: MonDReg=%h, required %h", MonDReg, exp_mon);
        end
    endtask

    task automatic test_timeout();
        int n;
        stuck = 1'b1;
        pulse(1'b1, 1'b0, 1'b0, jdo_a(8'h20, 1'b1));
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_read) n++;
            if (!busy) break;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL timeout_len: strobe cycles %0d, required 4", n);
        end
        checks++;
        if ({monitor_error, monitor_ready, busy} !== 3'b100 || MonDReg !== exp_mon) begin
            errors++;
            $display("FAIL timeout_status: err/rdy/busy=%b MonDReg=%h, required 100 %h",
                     {monitor_error, monitor_ready, busy}, MonDReg, exp_mon);
        end
        pulse(1'b1, 1'b0, 1'b0, jdo_a(8'h30, 1'b0));
        pulse(1'b0, 1'b1, 1'b0, jdo_b(32'h0BADF00D));
        wait_idle("wr_timeout");
        exp_mon = 32'h0BADF00D;
        checks++;
        if (monitor_error !== 1'b1 || MonDReg !== exp_mon) begin
            errors++;
            $display("FAIL wr_timeout: err=%b MonDReg=%h, required 1 %h",
                     monitor_error, MonDReg, exp_mon);
        end
        stuck = 1'b0;
        push(1'b0, 8'h31, 32'h0, 1);
        pulse(1'b0, 1'b0, 1'b1, 38'h0);
        wait_idle("no_post_inc");
        exp_mon = mem_model[8'h31];
        checks++;
        if (MonDReg !== exp_mon || monitor_error !== 1'b0) begin
            errors++;
            $display("FAIL no_post_inc: MonDReg=%h err=%b, required %h 0",
                     MonDReg, monitor_error, exp_mon);
        end
    endtask

    task automatic test_reject();
        int n;
        debugack = 1'b0;
        pulse(1'b1, 1'b0, 1'b0, jdo_a(8'h40, 1'b1));
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_read || mem_write || busy) n++;
        end
        checks++;
        if (n != 0 || {monitor_error, monitor_ready} !== 2'b10) begin
            errors++;
            $display("FAIL no_debugack: active cycles %0d err/rdy=%b, required 0 10",
                     n, {monitor_error, monitor_ready});
        end
        debugack = 1'b1;
        stall_target = 3;
        push(1'b0, 8'h40, 32'h0, 4);
        pulse(1'b1, 1'b0, 1'b0, jdo_a(8'h40, 1'b1));
        pulse(1'b1, 1'b0, 1'b0, jdo_a(8'h50, 1'b1));
        @(negedge clk);
        checks++;
        if (monitor_error !== 1'b1 || mem_address !== 8'h40 || mem_read !== 1'b1) begin
            errors++;
            $display("FAIL busy_reject: err=%b addr=%h rd=%b, required 1 40 1",
                     monitor_error, mem_address, mem_read);
        end
        wait_idle("busy_read");
        exp_mon = mem_model[8'h40];
        checks++;
        if (MonDReg !== exp_mon || monitor_ready !== 1'b1) begin
            errors++;
            $display("FAIL busy_read: MonDReg=%h ready=%b, required %h 1",
                     MonDReg, monitor_ready, exp_mon);
        end
        stall_target = 0;
        push(1'b0, 8'h41, 32'h0, 1);
        pulse(1'b0, 1'b0, 1'b1, 38'h0);
        wait_idle("busy_addr_kept");
    endtask

    task automatic test_priority();
        logic [37:0] j;
        j = jdo_a(8'h60, 1'b1);
        push(1'b0, 8'h60, 32'h0, 1);
        pulse(1'b1, 1'b1, 1'b1, j);
        wait_idle("priority");
        exp_mon = mem_model[8'h60];
        checks++;
        if (MonDReg !== exp_mon || mem_writedata !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL priority: MonDReg=%h wdata=%h, required %h 0badf00d",
                     MonDReg, mem_writedata, exp_mon);
        end
    endtask

    task automatic test_reset_mid_write();
        stuck = 1'b1;
        pulse(1'b0, 1'b1, 1'b0, jdo_b(32'h77));
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b1) begin
            errors++;
            $display("FAIL wr_before_reset: mem_write=%b, required 1", mem_write);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_read, mem_write, busy, monitor_ready, monitor_error} !== 5'b0 ||
            mem_address !== 8'h0 || MonDReg !== 32'h0 || mem_writedata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_write: flags=%b addr=%h MonDReg=%h wdata=%h, required 0",
                     {mem_read, mem_write, busy, monitor_ready, monitor_error},
                     mem_address, MonDReg, mem_writedata);
        end
        stuck = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        stall_target = 0;
        stuck = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        debugack = 1'b1;
        for (int i = 0; i < 256; i++) begin
            mem_model[i] = {8'hA5, 8'(i), 8'h5A, 8'(255 - i)};
        end
        mem_model[8'h10] = 32'hCAFEF00D;
        test_reset();
        test_read();
        test_write_wait();
        test_wrap();
        test_timeout();
        test_reject();
        test_priority();
        test_reset_mid_write();
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d accesses outstanding, required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
